// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory arbiter
//
// Purpose : default widths, requester id type, in-flight tag layout and
//           arbitration mode encodings used by data_mem_arbiter and its tag pipe.
// Contents: DMEM_ADDR_W, DMEM_DATA_W, port_id_t, tag_t, TAG_NONE,
//           ARB_FIXED_PRIORITY, ARB_ROUND_ROBIN.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    // Requester identity carried alongside each in-flight read.
    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_AUX  = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, id: PORT_CORE};

    localparam int ARB_FIXED_PRIORITY = 0;
    localparam int ARB_ROUND_ROBIN    = 1;

endpackage

// File: rtl/dmem_tag_pipe.sv
// rtl/dmem_tag_pipe.sv - fixed-depth shift register of read tags
//
// Purpose : follows each accepted request through the memory pipeline so the
//           read data can be steered to the requester that issued it.
// Ports   : clk     - clock
//           clr     - synchronous clear, drops every in-flight tag
//           tag_in  - tag entering stage 0 this cycle (TAG_NONE when idle/write)
//           tag_out - last stage, aligned with the memory read data
module dmem_tag_pipe
    import dmem_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic clr,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-requester arbiter for a single pipelined data memory port
//
// Purpose : grants at most one of two requesters per cycle, registers the winning
//           request onto the memory port and routes fixed-latency read data back
//           to the issuing requester.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           p0_req_* / p1_req_* - valid/ready request channels (we, addr, wdata)
//           p0_rsp_* / p1_rsp_* - single-cycle read response pulses with data
//           mem_we/addr/din     - registered memory request
//           mem_dout            - memory read data, MEM_LATENCY edges after request
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int MEM_LATENCY  = 4,
    parameter int ARB_MODE     = ARB_FIXED_PRIORITY,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic             grant0;
    logic             grant1;
    logic             starved;
    port_id_t         last_grant;
    logic [CNT_W-1:0] starve_cnt;
    tag_t             tag_in;
    tag_t             tag_out;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Grant decision; nothing is accepted while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (ARB_MODE == ARB_ROUND_ROBIN) begin
                if (p0_req_valid && p1_req_valid) begin
                    grant0 = (last_grant == PORT_AUX);
                    grant1 = (last_grant == PORT_CORE);
                end else begin
                    grant0 = p0_req_valid;
                    grant1 = p1_req_valid;
                end
            end else begin
                // Core wins unless the aux port has waited STARVE_LIMIT cycles.
                grant1 = p1_req_valid && (!p0_req_valid || starved);
                grant0 = p0_req_valid && !grant1;
            end
        end
    end

    assign p0_req_ready = grant0;
    assign p1_req_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            last_grant <= PORT_AUX;
            starve_cnt <= '0;
        end else begin
            if (grant0) begin
                mem_we     <= p0_req_we;
                mem_addr   <= p0_req_addr;
                mem_din    <= p0_req_wdata;
                last_grant <= PORT_CORE;
            end else if (grant1) begin
                mem_we     <= p1_req_we;
                mem_addr   <= p1_req_addr;
                mem_din    <= p1_req_wdata;
                last_grant <= PORT_AUX;
            end else begin
                // Address and data hold so the memory sees no spurious change.
                mem_we <= 1'b0;
            end

            if (!p1_req_valid || grant1) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Only reads occupy a valid tag; writes complete on acceptance.
    always_comb begin
        tag_in = TAG_NONE;
        if (grant0) begin
            tag_in = '{valid: !p0_req_we, id: PORT_CORE};
        end else if (grant1) begin
            tag_in = '{valid: !p1_req_we, id: PORT_AUX};
        end
    end

    // One extra stage over the memory latency: stage 0 is loaded on the same
    // edge as the mem_* registers, the memory needs MEM_LATENCY more edges.
    dmem_tag_pipe #(
        .DEPTH (MEM_LATENCY + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .clr     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign p0_rsp_valid = tag_out.valid && (tag_out.id == PORT_CORE);
    assign p1_rsp_valid = tag_out.valid && (tag_out.id == PORT_AUX);
    assign p0_rsp_rdata = mem_dout;
    assign p1_rsp_rdata = mem_dout;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v0, we0, v1, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    logic          rdy0 [2];
    logic          rdy1 [2];
    logic          rv0  [2];
    logic          rv1  [2];
    logic [DW-1:0] rd0  [2];
    logic [DW-1:0] rd1  [2];
    logic          mwe  [2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] mdin [2];
    logic [DW-1:0] mdout[2];

    logic [DW-1:0] mem_model [2][1<<AW];
    logic [DW-1:0] rpipe     [2][LAT];

    int errors = 0;
    int checks = 0;

    // Index 0: fixed priority, index 1: round robin
    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .ARB_MODE(0), .STARVE_LIMIT(8)) u_fixed (
        .clk(clk), .rst(rst),
        .p0_req_valid(v0), .p0_req_ready(rdy0[0]), .p0_req_we(we0), .p0_req_addr(a0), .p0_req_wdata(d0),
        .p0_rsp_valid(rv0[0]), .p0_rsp_rdata(rd0[0]),
        .p1_req_valid(v1), .p1_req_ready(rdy1[0]), .p1_req_we(we1), .p1_req_addr(a1), .p1_req_wdata(d1),
        .p1_rsp_valid(rv1[0]), .p1_rsp_rdata(rd1[0]),
        .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_din(mdin[0]), .mem_dout(mdout[0])
    );

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .ARB_MODE(1), .STARVE_LIMIT(8)) u_rr (
        .clk(clk), .rst(rst),
        .p0_req_valid(v0), .p0_req_ready(rdy0[1]), .p0_req_we(we0), .p0_req_addr(a0), .p0_req_wdata(d0),
        .p0_rsp_valid(rv0[1]), .p0_rsp_rdata(rd0[1]),
        .p1_req_valid(v1), .p1_req_ready(rdy1[1]), .p1_req_we(we1), .p1_req_addr(a1), .p1_req_wdata(d1),
        .p1_rsp_valid(rv1[1]), .p1_rsp_rdata(rd1[1]),
        .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_din(mdin[1]), .mem_dout(mdout[1])
    );

    // Pipelined memory: samples mem_* one edge after they update, data out LAT edges after that update
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mwe[i]) mem_model[i][maddr[i]] <= mdin[i];
            rpipe[i][0] <= mem_model[i][maddr[i]];
            for (int s = 1; s < LAT; s++) rpipe[i][s] <= rpipe[i][s-1];
        end
    end
    assign mdout[0] = rpipe[0][LAT-1];
    assign mdout[1] = rpipe[1][LAT-1];

    // Drive one cycle of stimulus at the falling edge; outputs are sampled 1 ns later
    task automatic step(input logic irst,
                        input logic iv0, input logic iwe0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                        input logic iv1, input logic iwe1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1);
        @(negedge clk);
        rst = irst;
        v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
        v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mwe[i] !== 1'b0 || maddr[i] !== '0 || mdin[i] !== '0) begin
                errors++;
                $display("FAIL reset_mem dut%0d: got we=%b addr=%0d din=%h, expected 0/0/0", i, mwe[i], maddr[i], mdin[i]);
            end
            checks++;
            if (rv0[i] !== 1'b0 || rv1[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp dut%0d: got rv0=%b rv1=%b, expected 0/0", i, rv0[i], rv1[i]);
            end
        end
    endtask

    task automatic test_rst_blocks_grants();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b1, 1'b1, 10'd9, 32'h1234_0000 + 32'(c), 1'b1, 1'b1, 10'd9, 32'h5678_0000 + 32'(c));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rdy0[i] !== 1'b0 || rdy1[i] !== 1'b0 || mwe[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_block dut%0d cyc%0d: got rdy0=%b rdy1=%b we=%b, expected 0/0/0", i, c, rdy0[i], rdy1[i], mwe[i]);
                end
            end
        end
        idle();
    endtask

    task automatic preload();
        step(1'b0, 1'b1, 1'b1, 10'd1, 32'h1111_1111, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 10'd2, 32'h2222_2222, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 10'd7, 32'h0000_0055, 1'b0, 1'b0, '0, '0);
        for (int a = 16; a <= 28; a++) step(1'b0, 1'b1, 1'b1, 10'(a), 32'hA000_0000 + 32'(a), 1'b0, 1'b0, '0, '0);
        checks++;
        if (rdy0[0] !== 1'b1 || rdy0[1] !== 1'b1) begin
            errors++;
            $display("FAIL preload_ready: got %b/%b, expected 1/1", rdy0[0], rdy0[1]);
        end
        idle();
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rdy0[i] !== 1'b1 || rdy1[i] !== 1'b0) begin
                errors++;
                $display("FAIL wr_grant dut%0d: got rdy0=%b rdy1=%b, expected 1/0", i, rdy0[i], rdy1[i]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mwe[i] !== 1'b1 || maddr[i] !== 10'd5 || mdin[i] !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL wr_mem dut%0d: got we=%b addr=%0d din=%h, expected 1/5/deadbeef", i, mwe[i], maddr[i], mdin[i]);
            end
        end
        for (int s = 1; s <= 7; s++) begin
            idle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rv0[i] !== (s == 5) || rv1[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_latency dut%0d s%0d: got rv0=%b rv1=%b, expected %b/0", i, s, rv0[i], rv1[i], s == 5);
                end
                if (s == 5) begin
                    checks++;
                    if (rd0[i] !== 32'hDEAD_BEEF) begin
                        errors++;
                        $display("FAIL rd_data dut%0d: got %h, expected deadbeef", i, rd0[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic          g0 [25];
        logic          g1 [25];
        logic          o0 [25];
        logic          o1 [25];
        logic [DW-1:0] od0[25];
        logic [DW-1:0] od1[25];
        for (int j = 0; j < 25; j++) begin
            if (j < 18) step(1'b0, 1'b1, 1'b0, 10'd1, '0, 1'b1, 1'b0, 10'd2, '0);
            else idle();
            g0[j] = rdy0[0]; g1[j] = rdy1[0];
            o0[j] = rv0[0]; o1[j] = rv1[0]; od0[j] = rd0[0]; od1[j] = rd1[0];
        end
        for (int j = 0; j < 18; j++) begin
            checks++;
            if (g1[j] !== (j == 8 || j == 17) || g0[j] !== !(j == 8 || j == 17)) begin
                errors++;
                $display("FAIL fixed_grant cyc%0d: got g0=%b g1=%b, expected p1=%b", j, g0[j], g1[j], j == 8 || j == 17);
            end
        end
        for (int j = 0; j < 25; j++) begin
            logic issued, to_p1;
            issued = (j >= 5) && (j - 5 < 18);
            to_p1  = issued && (j - 5 == 8 || j - 5 == 17);
            checks++;
            if (o0[j] !== (issued && !to_p1) || o1[j] !== to_p1) begin
                errors++;
                $display("FAIL fixed_rsp cyc%0d: got rv0=%b rv1=%b, expected %b/%b", j, o0[j], o1[j], issued && !to_p1, to_p1);
            end
            if (issued) begin
                checks++;
                if ((to_p1 && od1[j] !== 32'h2222_2222) || (!to_p1 && od0[j] !== 32'h1111_1111)) begin
                    errors++;
                    $display("FAIL fixed_data cyc%0d: got p0=%h p1=%h, expected %h on p%0d", j, od0[j], od1[j],
                             to_p1 ? 32'h2222_2222 : 32'h1111_1111, to_p1);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic          g0 [23];
        logic          g1 [23];
        logic          o0 [23];
        logic          o1 [23];
        logic [DW-1:0] od0[23];
        logic [DW-1:0] od1[23];
        for (int i = 0; i < 23; i++) begin
            if (i == 0) step(1'b0, 1'b1, 1'b0, 10'd1, '0, 1'b0, 1'b0, '0, '0);
            else if (i <= 16) step(1'b0, 1'b1, 1'b0, 10'(16 + (i - 1) / 2), '0, 1'b1, 1'b0, 10'(20 + i / 2), '0);
            else idle();
            g0[i] = rdy0[1]; g1[i] = rdy1[1];
            o0[i] = rv0[1]; o1[i] = rv1[1]; od0[i] = rd0[1]; od1[i] = rd1[1];
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (g1[i] !== ((i - 1) % 2 == 0) || g0[i] !== ((i - 1) % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant cyc%0d: got g0=%b g1=%b, expected p1=%b", i, g0[i], g1[i], (i - 1) % 2 == 0);
            end
        end
        for (int i = 0; i < 23; i++) begin
            int            k, jj;
            logic          issued, to_p1;
            logic [DW-1:0] want;
            k      = i - 5;
            jj     = k - 1;
            issued = (k >= 0) && (k <= 16);
            to_p1  = issued && (k >= 1) && (jj % 2 == 0);
            if (k == 0) want = 32'h1111_1111;
            else if (to_p1) want = 32'hA000_0000 + 32'(20 + jj / 2);
            else want = 32'hA000_0000 + 32'(16 + jj / 2);
            checks++;
            if (o0[i] !== (issued && !to_p1) || o1[i] !== to_p1) begin
                errors++;
                $display("FAIL rr_rsp cyc%0d: got rv0=%b rv1=%b, expected %b/%b", i, o0[i], o1[i], issued && !to_p1, to_p1);
            end
            if (issued) begin
                checks++;
                if ((to_p1 ? od1[i] : od0[i]) !== want) begin
                    errors++;
                    $display("FAIL rr_data cyc%0d: got %h, expected %h", i, to_p1 ? od1[i] : od0[i], want);
                end
            end
        end
    endtask

    task automatic test_raw();
        step(1'b0, 1'b1, 1'b1, 10'd7, 32'h0000_0001, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd7, '0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rdy1[i] !== 1'b1) begin
                errors++;
                $display("FAIL raw_grant dut%0d: got rdy1=%b, expected 1", i, rdy1[i]);
            end
        end
        for (int s = 1; s <= 6; s++) begin
            idle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rv1[i] !== (s == 5) || rv0[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL raw_rsp dut%0d s%0d: got rv0=%b rv1=%b, expected 0/%b", i, s, rv0[i], rv1[i], s == 5);
                end
                if (s == 5) begin
                    checks++;
                    if (rd1[i] !== 32'h0000_0001) begin
                        errors++;
                        $display("FAIL raw_data dut%0d: got %h, expected 00000001", i, rd1[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 10; c++) begin
            case (c)
                0: step(1'b0, 1'b1, 1'b0, 10'd1,  '0, 1'b0, 1'b0, '0, '0);
                1: step(1'b0, 1'b1, 1'b0, 10'd2,  '0, 1'b0, 1'b0, '0, '0);
                2: step(1'b0, 1'b1, 1'b0, 10'd16, '0, 1'b0, 1'b0, '0, '0);
                4: step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
                default: idle();
            endcase
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rv0[i] !== 1'b0 || rv1[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_drop dut%0d cyc%0d: got rv0=%b rv1=%b, expected 0/0", i, c, rv0[i], rv1[i]);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0, 10'd2, '0, 1'b0, 1'b0, '0, '0);
        for (int s = 1; s <= 6; s++) begin
            idle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rv0[i] !== (s == 5) || (s == 5 && rd0[i] !== 32'h2222_2222)) begin
                    errors++;
                    $display("FAIL post_rst_read dut%0d s%0d: got rv0=%b data=%h, expected %b/22222222", i, s, rv0[i], rd0[i], s == 5);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0;
        v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0;
        test_reset();
        test_rst_blocks_grants();
        preload();
        test_write_read();
        test_fixed_priority();
        test_round_robin();
        test_raw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
